ebr_fifo_ctrl_w18r9: RTL

Single-clock FIFO controller that sequences one pseudo-dual-port EBR, the PDPW8KC primitive, configured as 512x18 for writes and 1024x9 for reads. It accepts 18-bit words on a push interface and returns 9-bit bytes on a pop interface. The low byte of each word is returned first. The block owns the write and read pointers, byte occupancy, status flags and all EBR control pins. It sits between a word-wide producer (e.g. a sample packer) and a byte-wide consumer (e.g. a UART or SPI shifter).

---
 rtl/ebr_fifo_ctrl_w18r9.sv | 95 +++++++++
 1 files changed

// File: rtl/ebr_fifo_ctrl_w18r9.sv
// FIFO controller around one PDPW8KC EBR: 18-bit words pushed at 512x18, 9-bit bytes popped at 1024x9.
// Low byte of each word pops first; all EBR control pins are driven from here.
module ebr_fifo_ctrl_w18r9 #(
  parameter string       REGMODE       = "NOREG",
  parameter int unsigned AFULL_THRESH  = 1008,
  parameter int unsigned AEMPTY_THRESH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WR_EN,
  input  logic [17:0] WR_DATA,
  input  logic        RD_EN,
  output logic [8:0]  RD_DATA,
  output logic        RD_VALID,
  output logic        FULL,
  output logic        EMPTY,
  output logic        AFULL,
  output logic        AEMPTY,
  output logic [10:0] COUNT,
  output logic        WR_OVF,
  output logic        RD_UNF,
  output logic [17:0] EBR_DI,
  output logic [8:0]  EBR_ADW,
  output logic [1:0]  EBR_BE,
  output logic        EBR_CEW,
  output logic [12:0] EBR_ADR,
  output logic        EBR_CER,
  output logic        EBR_OCER,
  output logic        EBR_RST,
  input  logic [8:0]  EBR_DO
);

  localparam int unsigned WA_W     = 9;
  localparam int unsigned RA_W     = 10;
  localparam int unsigned CNT_W    = 11;
  localparam int unsigned FULL_AT  = 1023;
  localparam bit          OUTREG   = (REGMODE == "OUTREG");
  localparam int unsigned RV_DEPTH = OUTREG ? 2 : 1;

  logic [WA_W-1:0]     wr_ptr;
  logic [RA_W-1:0]     rd_ptr;
  logic [RV_DEPTH-1:0] rv_pipe;
  logic                wr_acc;
  logic                rd_acc;
  logic [CNT_W-1:0]    count_next;

  // Acceptance is gated by reset so the EBR sees no access while RST is high.
  always_comb begin
    wr_acc     = WR_EN & ~FULL & ~RST;
    rd_acc     = RD_EN & ~EMPTY & ~RST;
    count_next = COUNT;
    if (wr_acc) count_next = count_next + CNT_W'(2);
    if (rd_acc) count_next = count_next - CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      COUNT   <= '0;
      EMPTY   <= 1'b1;
      AEMPTY  <= 1'b1;
      FULL    <= 1'b0;
      AFULL   <= 1'b0;
      WR_OVF  <= 1'b0;
      RD_UNF  <= 1'b0;
      rv_pipe <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + WA_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + RA_W'(1);
      COUNT   <= count_next;
      EMPTY   <= (count_next == '0);
      AEMPTY  <= (count_next <= CNT_W'(AEMPTY_THRESH));
      FULL    <= (count_next >= CNT_W'(FULL_AT));
      AFULL   <= (count_next >= CNT_W'(AFULL_THRESH));
      WR_OVF  <= WR_EN & FULL;
      RD_UNF  <= RD_EN & EMPTY;
      // Valid tracks the EBR read latency (1 for NOREG, 2 for OUTREG).
      rv_pipe <= RV_DEPTH'({rv_pipe, rd_acc});
    end
  end

  assign RD_VALID = rv_pipe[RV_DEPTH-1];
  assign RD_DATA  = EBR_DO;

  assign EBR_DI   = WR_DATA;
  assign EBR_ADW  = wr_ptr;
  assign EBR_BE   = 2'b11;
  assign EBR_CEW  = wr_acc;
  assign EBR_ADR  = {rd_ptr, 3'b000};
  assign EBR_CER  = rd_acc;
  assign EBR_OCER = 1'b1;
  assign EBR_RST  = RST;

endmodule
